// File: rtl/ldiv_pkg.sv
// -----------------------------------------------------------------------------
// ldiv_pkg
//   Shared constants and types for the signed long divider and the blocks that
//   sit around it.
//
//   Contents:
//     NUMERATOR_WIDTH / DENOMINATOR_WIDTH / QUOTIENT_WIDTH : default widths
//     RESULT_WIDTH   : packed width of one {quotient, remainder} pair
//     ldiv_result_t  : packed {quotient, remainder} result record
//     clog2()        : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package ldiv_pkg;

    localparam int NUMERATOR_WIDTH   = 24;
    localparam int DENOMINATOR_WIDTH = 20;
    localparam int QUOTIENT_WIDTH    = 24;

    // The remainder takes the sign of the numerator and never exceeds its
    // magnitude, so it is sized from the numerator width.
    localparam int RESULT_WIDTH = QUOTIENT_WIDTH + NUMERATOR_WIDTH;

    typedef struct packed {
        logic signed [QUOTIENT_WIDTH-1:0]  quotient;
        logic signed [NUMERATOR_WIDTH-1:0] remainder;
    } ldiv_result_t;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : ldiv_pkg

// File: rtl/ldiv_fifo_fwft.sv
// -----------------------------------------------------------------------------
// ldiv_fifo_fwft
//   Generic first-word-fall-through synchronous FIFO. The head entry is
//   presented on rdata_o in the cycle after it is written, and rdata_o reads
//   as zero whenever the FIFO is empty.
//
//   Parameters:
//     WIDTH : entry width in bits
//     DEPTH : number of entries; must be a power of two, >= 2
//
//   Ports:
//     clk      in   rising-edge clock
//     resetb   in   asynchronous active-low reset
//     push_i   in   write wdata_i (ignored when full unless popping as well)
//     wdata_i  in   WIDTH  write data
//     pop_i    in   remove head entry (ignored when empty)
//     rdata_o  out  WIDTH  head entry, zero when empty
//     full_o   out  count == DEPTH
//     empty_o  out  count == 0
//     count_o  out  clog2(DEPTH)+1  number of stored entries
// -----------------------------------------------------------------------------
module ldiv_fifo_fwft
    import ldiv_pkg::*;
#(
    parameter int WIDTH = RESULT_WIDTH,
    parameter int DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   count_o
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push_ok;
    logic pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    // A pop frees the slot in the same cycle, so a push into a full FIFO is
    // accepted only when the head leaves simultaneously.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointers carry no wrap bit; DEPTH is a power of two so they wrap
    // naturally, and empty/full come from the count instead.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : ldiv_fifo_fwft

// File: rtl/ldiv_result_buffer.sv
// -----------------------------------------------------------------------------
// ldiv_result_buffer
//   Adds backpressure to the valid-only, fixed-latency output of the pipelined
//   signed long divider. Every result is captured into a FWFT FIFO and offered
//   to the consumer with valid/ready. A credit counter tracks divisions in
//   flight plus stored results so the issuer can never overrun the FIFO.
//
//   Optional feature (macro LDIV_RBUF_ERR_EN):
//     defined   : err is a sticky flag set on an issue without credit or on a
//                 result arriving at a full FIFO with no pop; cleared by reset
//     undefined : err is tied low
//
//   Parameters:
//     QUOTIENT_WIDTH  : quotient width (signed)
//     NUMERATOR_WIDTH : remainder width (signed)
//     DEPTH           : FIFO entries, power of two, >= divider latency + 1
//
//   Ports:
//     clk            in   rising-edge clock
//     resetb         in   asynchronous active-low reset
//     div_issue      in   a division is launched this cycle
//     issue_ok       out  credit available for div_issue
//     div_valid      in   divider result valid
//     div_quotient   in   divider quotient
//     div_remainder  in   divider remainder
//     out_valid      out  head entry valid
//     out_ready      in   consumer accepts head entry
//     out_quotient   out  head quotient (0 when empty)
//     out_remainder  out  head remainder (0 when empty)
//     occupancy      out  entries currently stored
//     err            out  sticky protocol error
// -----------------------------------------------------------------------------
module ldiv_result_buffer
    import ldiv_pkg::*;
#(
    parameter int QUOTIENT_WIDTH  = ldiv_pkg::QUOTIENT_WIDTH,
    parameter int NUMERATOR_WIDTH = ldiv_pkg::NUMERATOR_WIDTH,
    parameter int DEPTH           = 32
) (
    input  logic                              clk,
    input  logic                              resetb,
    input  logic                              div_issue,
    output logic                              issue_ok,
    input  logic                              div_valid,
    input  logic signed [QUOTIENT_WIDTH-1:0]  div_quotient,
    input  logic signed [NUMERATOR_WIDTH-1:0] div_remainder,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [QUOTIENT_WIDTH-1:0]  out_quotient,
    output logic signed [NUMERATOR_WIDTH-1:0] out_remainder,
    output logic [clog2(DEPTH):0]             occupancy,
    output logic                              err
);

    localparam int CW = clog2(DEPTH) + 1;
    localparam int W  = QUOTIENT_WIDTH + NUMERATOR_WIDTH;

    logic [W-1:0]  fifo_wdata;
    logic [W-1:0]  fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop;

    logic [CW-1:0] credit_q, credit_d;

    // -------------------------------------------------------------------------
    // Result storage
    // -------------------------------------------------------------------------
    assign fifo_wdata = {div_quotient, div_remainder};
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;

    ldiv_fifo_fwft #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .push_i  (div_valid),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_quotient  = fifo_rdata[W-1 -: QUOTIENT_WIDTH];
    assign out_remainder = fifo_rdata[NUMERATOR_WIDTH-1:0];
    assign occupancy     = fifo_count;

    // -------------------------------------------------------------------------
    // Issue credit: one credit is held from issue until the result is popped,
    // covering both the divider pipeline and the FIFO slot.
    // -------------------------------------------------------------------------
    // Derived from the register only, so there is no div_issue -> issue_ok path.
    assign issue_ok = (credit_q < CW'(DEPTH));

    always_comb begin
        credit_d = credit_q;
        if (div_issue && !pop) begin
            // Saturate so an over-issue cannot wrap the counter.
            if (credit_q != CW'(DEPTH)) begin
                credit_d = credit_q + CW'(1);
            end
        end else if (pop && !div_issue) begin
            if (credit_q != '0) begin
                credit_d = credit_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    // -------------------------------------------------------------------------
    // Protocol error flag
    // -------------------------------------------------------------------------
`ifdef LDIV_RBUF_ERR_EN
    logic issue_viol;
    logic drop_viol;
    logic err_q, err_d;

    assign issue_viol = div_issue && !issue_ok;
    assign drop_viol  = div_valid && fifo_full && !pop;
    assign err_d      = err_q || issue_viol || drop_viol;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

`ifndef SYNTHESIS
    logic [63:0] cycle_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
        end
    end

    always @(posedge clk) begin
        if (resetb && issue_viol) begin
            $display("ldiv_result_buffer: issue without credit at cycle %0d", cycle_q);
        end
        if (resetb && drop_viol) begin
            $display("ldiv_result_buffer: result dropped, FIFO full at cycle %0d", cycle_q);
        end
    end
`endif
`else
    // Full is only consumed by the error detection.
    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;
    assign err              = 1'b0;
`endif

endmodule : ldiv_result_buffer
